// File: rtl/adc_uart_framer_pkg.sv
// adc_uart_framer_pkg: framer state encoding, default sync byte and header packing
package adc_uart_framer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LATCH, S_SEND, S_WAIT, S_DONE} state_e;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic logic [7:0] hdr_byte(logic [3:0] seq, logic [3:0] ch);
    return {seq, ch};
  endfunction
endpackage

// File: rtl/adc_uart_framer_rr_arbiter.sv
// rr_arbiter: grants the first requester after the last-grant pointer, circularly
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // scan farthest to nearest so the nearest requester after ptr_i wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/adc_uart_framer.sv
// adc_uart_framer: round-robin drain of per-channel FIFOs into SYNC/header/data UART frames
// Define ADC_UART_FRAMER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module adc_uart_framer import adc_uart_framer_pkg::*; #(
  parameter int          DATA_WIDTH = 13,
  parameter int          CH_NUM     = 2,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CH_NUM-1:0]            ch_fifo_empty_i,
  output logic [CH_NUM-1:0]            ch_fifo_rd_en_o,
  input  logic [CH_NUM*DATA_WIDTH-1:0] ch_fifo_data_i,
  output logic                         tx_start_o,
  output logic [7:0]                   tx_data_o,
  input  logic                         tx_done_i,
  output logic                         busy_o,
  output logic [15:0]                  frame_cnt_o
);
  localparam int NB = (DATA_WIDTH + 7) / 8;
  localparam int SW = NB * 8;
  localparam int IW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
`ifdef ADC_UART_FRAMER_CHECKSUM_EN
  localparam int NBYTES = NB + 3;
`else
  localparam int NBYTES = NB + 2;
`endif
  localparam int XW = $clog2(NBYTES + 1);
  state_e            state_q;
  logic [IW-1:0]     ch_q, rr_q, gnt_idx;
  logic [CH_NUM-1:0] gnt, rd_en_q;
  logic              any;
  logic [3:0]        seq_q;
  logic [15:0]       frame_cnt_q;
  logic [SW-1:0]     sample_q;
  logic [XW-1:0]     idx_q, idx_d;
  logic [7:0]        hdr, data_byte, byte_d, tx_data_q;
  logic              tx_start_q;
  rr_arbiter #(.N(CH_NUM)) u_arb (
    .req_i(~ch_fifo_empty_i),
    .ptr_i(rr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(any)
  );
  assign hdr       = hdr_byte(seq_q, 4'(ch_q));
  assign idx_d     = idx_q + XW'(1);
  assign data_byte = 8'(sample_q >> (8 * (NB + 1 - int'(idx_d))));
`ifdef ADC_UART_FRAMER_CHECKSUM_EN
  logic [7:0] cks;
  always_comb begin
    cks = hdr;
    for (int b = 0; b < NB; b++) cks = cks ^ sample_q[b*8 +: 8];
  end
  assign byte_d = idx_d == XW'(1) ? hdr : idx_d == XW'(NB + 2) ? cks : data_byte;
`else
  assign byte_d = idx_d == XW'(1) ? hdr : data_byte;
`endif
  // tx byte and strobes are registered on entry to SEND so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      rr_q        <= IW'(CH_NUM - 1);
      seq_q       <= '0;
      frame_cnt_q <= '0;
      sample_q    <= '0;
      idx_q       <= '0;
      rd_en_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      rd_en_q    <= '0;
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (en && any) begin
          ch_q    <= gnt_idx;
          rd_en_q <= gnt;
          state_q <= S_RD;
        end
        S_RD: state_q <= S_LATCH;
        S_LATCH: begin
          sample_q   <= SW'(ch_fifo_data_i[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH]);
          idx_q      <= '0;
          tx_start_q <= 1'b1;
          tx_data_q  <= SYNC_BYTE;
          state_q    <= S_SEND;
        end
        S_SEND: state_q <= S_WAIT;
        S_WAIT: if (tx_done_i) begin
          idx_q <= idx_d;
          if (idx_d == XW'(NBYTES)) state_q <= S_DONE;
          else begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_d;
            state_q    <= S_SEND;
          end
        end
        S_DONE: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          seq_q       <= seq_q + 4'd1;
          rr_q        <= ch_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign ch_fifo_rd_en_o = rd_en_q;
  assign tx_start_o      = tx_start_q;
  assign tx_data_o       = tx_data_q;
  assign busy_o          = state_q != S_IDLE;
  assign frame_cnt_o     = frame_cnt_q;
endmodule

// File: tb/tb_adc_uart_framer.sv
// tb_adc_uart_framer: randomized scoreboard bench with FIFO and uart_tx models
`timescale 1ns/1ps
module tb_adc_uart_framer;
  localparam int DW = 13;
  localparam int CH = 2;
  localparam int NB = 2;
  logic clk = 0, rst_n = 1, en = 0, tx_done = 0;
  logic [CH-1:0] empty, rd_en;
  logic [CH*DW-1:0] fdata;
  logic tx_start, busy;
  logic [7:0] tx_data, held;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  int mptr = CH - 1, mseq = 0, mframes = 0, dly = 20, starts = 0, rd_pulses = 0, cnt = 0;
  logic [DW-1:0] fq [CH][$];
  logic [DW-1:0] mq [CH][$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  adc_uart_framer #(.DATA_WIDTH(DW), .CH_NUM(CH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ch_fifo_empty_i(empty), .ch_fifo_rd_en_o(rd_en), .ch_fifo_data_i(fdata),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
    .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic upd();
    for (int k = 0; k < CH; k++) empty[k] = fq[k].size() == 0;
  endtask

  task automatic push(int c, logic [DW-1:0] v);
    fq[c].push_back(v);
    mq[c].push_back(v);
    upd();
  endtask

  // reference: frames in round-robin order over whatever samples are queued
  task automatic predict(int n);
    for (int f = 0; f < n; f++) begin
      int c;
      logic [DW-1:0] s;
      logic [7:0] x, b;
      c = -1;
      for (int i = 1; i <= CH; i++)
        if (c < 0 && mq[(mptr + i) % CH].size() > 0) c = (mptr + i) % CH;
      if (c < 0) break;
      s = mq[c].pop_front();
      exp_q.push_back(8'hA5);
      x = 8'((mseq << 4) | c);
      exp_q.push_back(x);
      for (int j = NB - 1; j >= 0; j--) begin
        b = 8'(s >> (8 * j));
        x = x ^ b;
        exp_q.push_back(b);
      end
`ifdef ADC_UART_FRAMER_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      mptr = c;
      mseq = (mseq + 1) % 16;
      mframes++;
    end
  endtask

  task automatic drain(int limit, string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, " drained"}, int'(i < limit), 1);
    check({name, " frame_cnt"}, int'(frame_cnt), mframes & 16'hFFFF);
  endtask

  task automatic wait_starts(int n, string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (starts >= n) break;
      @(negedge clk);
    end
    check({name, " start seen"}, int'(starts >= n), 1);
  endtask

  task automatic check_zero(string name);
    check({name, " rd_en"}, int'(rd_en), 0);
    check({name, " tx_start"}, int'(tx_start), 0);
    check({name, " tx_data"}, int'(tx_data), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // BRAM FIFO model: one-cycle read latency
  initial forever begin
    @(negedge clk);
    if (|rd_en) begin
      rd_pulses++;
      check("rd_en onehot", int'($onehot(rd_en)), 1);
      for (int k = 0; k < CH; k++) if (rd_en[k]) begin
        check("rd_en nonempty", int'(fq[k].size() > 0), 1);
        if (fq[k].size() > 0) fdata[k*DW +: DW] = fq[k].pop_front();
      end
      upd();
    end
  end

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      starts++;
      check("tx byte available", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("tx byte", int'(tx_data), int'(exp_q.pop_front()));
    end
  end

  // uart_tx model: tx_done pulse dly cycles after each start
  initial forever begin
    @(negedge clk);
    tx_done = 0;
    if (!rst_n) cnt = 0;
    else if (tx_start) begin
      check("no restart while waiting", cnt, 0);
      held = tx_data;
      cnt = dly;
    end else if (cnt > 0) begin
      check("tx_data hold", int'(tx_data), int'(held));
      check("busy while waiting", int'(busy), 1);
      cnt--;
      if (cnt == 0) tx_done = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n0, n1, snap;
    empty = '1;
    fdata = '0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    en = 1;
    repeat (10) @(negedge clk);
    check("idle with empty fifos", int'(busy), 0);

    push(0, 13'h1ABC);
    predict(1);
    drain(300, "single");

    push(0, 13'h0123);
    push(1, 13'h0456);
    push(0, DW'($urandom));
    predict(3);
    drain(600, "two channel");

    dly = 500;
    push(1, DW'($urandom));
    predict(1);
    drain(3000, "slow done");
    dly = 20;

    for (int i = 0; i < 17; i++) push(0, DW'($urandom));
    predict(17);
    drain(17 * 120, "seq wrap");

    for (int r = 0; r < 4; r++) begin
      dly = $urandom_range(2, 30);
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        if (i < n0) push(0, DW'($urandom));
        if (i < n1) push(1, DW'($urandom));
      end
      predict(n0 + n1);
      drain((n0 + n1) * 4 * (dly + 6) + 100, "random mix");
    end
    dly = 20;

    base = starts;
    for (int i = 0; i < 3; i++) push(0, DW'($urandom));
    predict(1);
    wait_starts(base + 3, "en drop");
    en = 0;
    drain(300, "en drop");
    snap = rd_pulses;
    repeat (300) @(negedge clk);
    check("no read after en low", rd_pulses - snap, 0);
    check("idle after en low", int'(busy), 0);

    base = starts;
    en = 1;
    predict(1);
    wait_starts(base + 2, "mid reset");
    @(posedge clk);
    #2 rst_n = 0;
    en = 0;
    #1 check_zero("mid reset");
    exp_q.delete();
    mptr = CH - 1;
    mseq = 0;
    mframes = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    predict(1);
    en = 1;
    drain(300, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
